// File: rtl/seq_cla_addsub_pkg.sv
// Shared definitions for the sequential carry-lookahead add/subtract unit.
//   DATA_WIDTH_DEF / CHUNK_DEF : default operand width and bits handled per cycle
//   CLA_GRP                    : lookahead group size inside a chunk
//   state_t                    : controller states (IDLE / RUN / DONE)
package seq_cla_addsub_pkg;

  localparam int DATA_WIDTH_DEF = 64;
  localparam int CHUNK_DEF      = 16;
  localparam int CLA_GRP        = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_cla_addsub_if.sv
// Handshake bundle for seq_cla_addsub.
//   in_valid/in_ready   : operand handshake (a, b, sub)
//   out_valid/out_ready : result handshake (sum, c_out, and ovf when ADDSUB_OVF_EN is defined)
// master = operand producer / result consumer, slave = the add/subtract unit.
interface seq_cla_addsub_if
  import seq_cla_addsub_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] a;
  logic [DATA_WIDTH-1:0] b;
  logic                  sub;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] sum;
  logic                  c_out;
`ifdef ADDSUB_OVF_EN
  logic                  ovf;

  modport master (
    output in_valid, a, b, sub, out_ready,
    input  in_ready, out_valid, sum, c_out, ovf
  );
  modport slave (
    input  in_valid, a, b, sub, out_ready,
    output in_ready, out_valid, sum, c_out, ovf
  );
`else
  modport master (
    output in_valid, a, b, sub, out_ready,
    input  in_ready, out_valid, sum, c_out
  );
  modport slave (
    input  in_valid, a, b, sub, out_ready,
    output in_ready, out_valid, sum, c_out
  );
`endif

endinterface

// File: rtl/seq_cla_addsub_cla_chunk.sv
// Combinational W-bit carry-lookahead adder built from 4-bit groups.
//   a, b     : W-bit addends
//   c_in     : carry into bit 0
//   s        : W-bit sum
//   c_out    : carry out of bit W-1
//   c_msb_in : carry into bit W-1 (only when ADDSUB_OVF_EN is defined)
// Inside a group the bit carries follow c[i+1] = g[i] | (c[i] & p[i]); the
// carry leaving a group comes from the group G/P terms, so no ripple spans
// more than one group.
module cla_chunk
  import seq_cla_addsub_pkg::*;
#(
  parameter int W = CHUNK_DEF
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         c_in,
  output logic [W-1:0] s,
`ifdef ADDSUB_OVF_EN
  output logic         c_msb_in,
`endif
  output logic         c_out
);

  localparam int NGRP = W / CLA_GRP;

  logic [W-1:0]    p;
  logic [W-1:0]    g;
  logic [W:0]      c;
  logic [NGRP-1:0] grp_p;
  logic [NGRP-1:0] grp_g;

  always_comb begin
    p     = a ^ b;
    g     = a & b;
    c     = '0;
    c[0]  = c_in;
    grp_p = '0;
    grp_g = '0;
    for (int k = 0; k < NGRP; k++) begin
      grp_p[k] = &p[k*CLA_GRP +: CLA_GRP];
      grp_g[k] = g[k*CLA_GRP+3]
               | (p[k*CLA_GRP+3] & g[k*CLA_GRP+2])
               | (p[k*CLA_GRP+3] & p[k*CLA_GRP+2] & g[k*CLA_GRP+1])
               | (p[k*CLA_GRP+3] & p[k*CLA_GRP+2] & p[k*CLA_GRP+1] & g[k*CLA_GRP]);
      for (int j = 0; j < CLA_GRP - 1; j++) begin
        c[k*CLA_GRP+j+1] = g[k*CLA_GRP+j] | (c[k*CLA_GRP+j] & p[k*CLA_GRP+j]);
      end
      c[k*CLA_GRP+CLA_GRP] = grp_g[k] | (grp_p[k] & c[k*CLA_GRP]);
    end
    s = p ^ c[W-1:0];
  end

  assign c_out = c[W];
`ifdef ADDSUB_OVF_EN
  assign c_msb_in = c[W-1];
`endif

endmodule

// File: rtl/seq_cla_addsub.sv
// Multi-cycle add/subtract unit: one CHUNK-bit slice per cycle, LSB first,
// with the inter-chunk carry (or inverted borrow) held in a register.
//   clk, rst : clock, synchronous active-high reset
//   bus      : seq_cla_addsub_if.slave (operand and result handshakes)
// Subtraction is A + ~B + 1: ~B is stored at acceptance and the +1 enters as
// the initial carry. c_out = 1 on subtract means no borrow (A >= B).
// Optional: define ADDSUB_OVF_EN to add bus.ovf, the signed overflow of the
// MSB slice (carry into MSB xor carry out of MSB).
// The interface DATA_WIDTH must equal this module's DATA_WIDTH, which must be
// a multiple of CHUNK; CHUNK must be a multiple of 4.
module seq_cla_addsub
  import seq_cla_addsub_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int CHUNK      = CHUNK_DEF
) (
  input logic             clk,
  input logic             rst,
  seq_cla_addsub_if.slave bus
);

  localparam int NCHUNK = DATA_WIDTH / CHUNK;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  state_t                state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  carry_q, carry_d;
  logic [DATA_WIDTH-1:0] a_q, a_d;
  logic [DATA_WIDTH-1:0] b_q, b_d;
  logic [DATA_WIDTH-1:0] sum_q, sum_d;
  logic                  c_out_q, c_out_d;
  logic                  out_valid_q, out_valid_d;
`ifdef ADDSUB_OVF_EN
  logic                  ovf_q, ovf_d;
  logic                  chunk_c_msb;
`endif

  logic [CHUNK-1:0]      chunk_s;
  logic                  chunk_co;
  logic                  last_chunk;

  assign last_chunk = (idx_q == IDX_W'(NCHUNK - 1));

  // Single lookahead slice, steered by idx_q every RUN cycle
  cla_chunk #(.W(CHUNK)) u_chunk (
    .a        (a_q[idx_q*CHUNK +: CHUNK]),
    .b        (b_q[idx_q*CHUNK +: CHUNK]),
    .c_in     (carry_q),
    .s        (chunk_s),
`ifdef ADDSUB_OVF_EN
    .c_msb_in (chunk_c_msb),
`endif
    .c_out    (chunk_co)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.in_valid) state_d = RUN;
      RUN:     if (last_chunk)   state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    bus.in_ready = (state_q == IDLE);
  end

  // Datapath next values
  always_comb begin
    idx_d       = idx_q;
    carry_d     = carry_q;
    a_d         = a_q;
    b_d         = b_q;
    sum_d       = sum_q;
    c_out_d     = c_out_q;
    out_valid_d = out_valid_q;
`ifdef ADDSUB_OVF_EN
    ovf_d       = ovf_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.a;
          b_d     = bus.sub ? ~bus.b : bus.b;
          carry_d = bus.sub;
          idx_d   = '0;
        end
      end
      RUN: begin
        sum_d[idx_q*CHUNK +: CHUNK] = chunk_s;
        carry_d = chunk_co;
        idx_d   = idx_q + 1'b1;
        if (last_chunk) begin
          idx_d       = '0;
          c_out_d     = chunk_co;
          out_valid_d = 1'b1;
`ifdef ADDSUB_OVF_EN
          ovf_d       = chunk_c_msb ^ chunk_co;
`endif
        end
      end
      DONE: begin
        if (bus.out_ready) out_valid_d = 1'b0;
      end
      default: ;
    endcase
  end

  // Control and visible-result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q       <= '0;
      carry_q     <= 1'b0;
      sum_q       <= '0;
      c_out_q     <= 1'b0;
      out_valid_q <= 1'b0;
`ifdef ADDSUB_OVF_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      idx_q       <= idx_d;
      carry_q     <= carry_d;
      sum_q       <= sum_d;
      c_out_q     <= c_out_d;
      out_valid_q <= out_valid_d;
`ifdef ADDSUB_OVF_EN
      ovf_q       <= ovf_d;
`endif
    end
  end

  // Operand registers carry no reset; they are always loaded before use
  always_ff @(posedge clk) begin
    a_q <= a_d;
    b_q <= b_d;
  end

  assign bus.sum       = sum_q;
  assign bus.c_out     = c_out_q;
  assign bus.out_valid = out_valid_q;
`ifdef ADDSUB_OVF_EN
  assign bus.ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_seq_cla_addsub.sv
// Directed bench for seq_cla_addsub (64-bit operands, 16-bit chunks).
module tb_seq_cla_addsub;

  localparam int DW      = 64;
  localparam int CW      = 16;
  localparam int LAT     = DW / CW;
  localparam int MAXWAIT = 20;

  typedef struct {
    string       name;
    logic [63:0] a;
    logic [63:0] b;
    logic        sub;
    logic [63:0] exp_sum;
    logic        exp_cout;
    logic        exp_ovf;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  seq_cla_addsub_if #(.DATA_WIDTH(DW)) bus ();

  seq_cla_addsub #(.DATA_WIDTH(DW), .CHUNK(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int lat;
    check({v.name, " in_ready"}, 64'(bus.in_ready), 64'd1);
    bus.in_valid = 1'b1;
    bus.a        = v.a;
    bus.b        = v.b;
    bus.sub      = v.sub;
    tick();
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < MAXWAIT) begin
      tick();
      lat++;
    end
    check({v.name, " latency"}, 64'(lat), 64'(LAT));
    check({v.name, " sum"}, bus.sum, v.exp_sum);
    check({v.name, " c_out"}, 64'(bus.c_out), 64'(v.exp_cout));
`ifdef ADDSUB_OVF_EN
    check({v.name, " ovf"}, 64'(bus.ovf), 64'(v.exp_ovf));
`endif
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check({v.name, " out_valid drop"}, 64'(bus.out_valid), 64'd0);
  endtask

  vec_t vecs[11];

  initial begin
    logic [63:0] held_sum;
    logic        held_c;

    vecs[0]  = '{"chain",      64'h0000_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'h0001_0000_0000_0000, 1'b0, 1'b0};
    vecs[1]  = '{"wrap",       64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'h0000_0000_0000_0000, 1'b1, 1'b0};
    vecs[2]  = '{"sub_borrow", 64'd5, 64'd7, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0};
    vecs[3]  = '{"sub_ok",     64'd7, 64'd5, 1'b1, 64'd2, 1'b1, 1'b0};
    vecs[4]  = '{"sub_zero",   64'h1234_5678_9ABC_DEF0, 64'd0, 1'b1, 64'h1234_5678_9ABC_DEF0, 1'b1, 1'b0};
    vecs[5]  = '{"pos_ovf",    64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1};
    vecs[6]  = '{"neg_ovf",    64'h8000_0000_0000_0000, 64'd1, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1};
    vecs[7]  = '{"mid_chunk",  64'h0000_0000_FFFF_0000, 64'h0000_0000_0001_0000, 1'b0, 64'h0000_0001_0000_0000, 1'b0, 1'b0};
    vecs[8]  = '{"zero_sub",   64'd0, 64'd0, 1'b1, 64'd0, 1'b1, 1'b0};
    vecs[9]  = '{"no_carry",   64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0};
    vecs[10] = '{"grp_carry",  64'h0000_0000_0000_000F, 64'd1, 1'b0, 64'h0000_0000_0000_0010, 1'b0, 1'b0};

    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.sub       = 1'b0;
    bus.out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    check("reset in_ready", 64'(bus.in_ready), 64'd1);
    check("reset out_valid", 64'(bus.out_valid), 64'd0);
    check("reset sum", bus.sum, 64'd0);
    check("reset c_out", 64'(bus.c_out), 64'd0);
`ifdef ADDSUB_OVF_EN
    check("reset ovf", 64'(bus.ovf), 64'd0);
`endif

    // Reset while an operation is in flight
    bus.in_valid = 1'b1;
    bus.a        = 64'd1;
    bus.b        = 64'd2;
    bus.sub      = 1'b0;
    tick();
    bus.in_valid = 1'b0;
    check("midrun in_ready busy", 64'(bus.in_ready), 64'd0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrun rst in_ready", 64'(bus.in_ready), 64'd1);
    check("midrun rst out_valid", 64'(bus.out_valid), 64'd0);
    check("midrun rst sum", bus.sum, 64'd0);
    check("midrun rst c_out", 64'(bus.c_out), 64'd0);
    for (int i = 0; i < 6; i++) begin
      check("midrun stays idle", 64'(bus.out_valid), 64'd0);
      tick();
    end

    foreach (vecs[i]) run_vec(vecs[i]);

    // Backpressure: result held while out_ready stays low, new operands ignored
    bus.in_valid = 1'b1;
    bus.a        = 64'h0000_0001_0000_FFFF;
    bus.b        = 64'h0000_0000_0000_0001;
    bus.sub      = 1'b0;
    tick();
    bus.in_valid = 1'b0;
    for (int i = 0; i < MAXWAIT && !bus.out_valid; i++) tick();
    check("bp out_valid", 64'(bus.out_valid), 64'd1);
    held_sum = bus.sum;
    held_c   = bus.c_out;
    check("bp sum", held_sum, 64'h0000_0001_0001_0000);
    check("bp c_out", 64'(held_c), 64'd0);
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = i[0];
      bus.a        = 64'hDEAD_BEEF_0000_0000 + 64'(i);
      bus.b        = 64'h1111_1111_1111_1111;
      tick();
      check("bp hold out_valid", 64'(bus.out_valid), 64'd1);
      check("bp hold in_ready", 64'(bus.in_ready), 64'd0);
      check("bp hold sum", bus.sum, 64'h0000_0001_0001_0000);
      check("bp hold c_out", 64'(bus.c_out), 64'd0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("bp release out_valid", 64'(bus.out_valid), 64'd0);
    check("bp release in_ready", 64'(bus.in_ready), 64'd1);

    // out_ready held high from before acceptance: ignored until DONE
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.a         = 64'd3;
    bus.b         = 64'd4;
    bus.sub       = 1'b0;
    tick();
    bus.in_valid  = 1'b0;
    for (int i = 0; i < LAT - 1; i++) begin
      tick();
      check("early rdy run out_valid", 64'(bus.out_valid), 64'd0);
    end
    tick();
    check("early rdy done out_valid", 64'(bus.out_valid), 64'd1);
    check("early rdy sum", bus.sum, 64'd7);
    check("early rdy in_ready", 64'(bus.in_ready), 64'd0);
    tick();
    check("early rdy consumed", 64'(bus.out_valid), 64'd0);
    check("early rdy in_ready back", 64'(bus.in_ready), 64'd1);
    bus.out_ready = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
